// File: rtl/typing_session_core_if.sv
// Bus bundle for typing_session_core: UART rx/tx handshake, passage ROM port,
// stopwatch control and score outputs. The slave side is the core.
interface typing_session_core_if #(
  parameter int ADDR_W = 11,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 12
);
  logic [7:0]        rx_byte;
  logic              rx_dv;
  logic [SEL_W-1:0]  passage_sel;
  logic [7:0]        rom_dout;
  logic [ADDR_W-1:0] rom_addr;
  logic              timer_at_end;
  logic              stopwatch_rst;
  logic              stopwatch_start;
  logic              tx_busy;
  logic [7:0]        tx_byte;
  logic              tx_go;
  logic [CNT_W-1:0]  correct_cnt;
  logic [CNT_W-1:0]  error_cnt;
  logic              game_done;

  // Environment side: UART, ROM and stopwatch models drive the inputs.
  modport master (
    output rx_byte, rx_dv, passage_sel, rom_dout, timer_at_end, tx_busy,
    input  rom_addr, stopwatch_rst, stopwatch_start, tx_byte, tx_go,
           correct_cnt, error_cnt, game_done
  );

  // Core side.
  modport slave (
    input  rx_byte, rx_dv, passage_sel, rom_dout, timer_at_end, tx_busy,
    output rom_addr, stopwatch_rst, stopwatch_start, tx_byte, tx_go,
           correct_cnt, error_cnt, game_done
  );
endinterface

// File: rtl/typing_session_core.sv
// Typing-test session core: sequences a game over one passage of the character
// ROM, scores keystrokes, echoes them over the UART and drives the stopwatch.
// All outputs are registered; the FSM needs no external control strobes.
module typing_session_core #(
  parameter int         ADDR_W     = 11,
  parameter int         SEL_W      = 2,
  parameter int         CNT_W      = 12,
  parameter bit         STRICT     = 1'b1,
  parameter logic [7:0] START_CHAR = 8'h0d,
  parameter logic [7:0] END_CHAR   = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  typing_session_core_if.slave bus
);
  localparam int                OFF_W    = ADDR_W - SEL_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]        CR_CHAR  = 8'h0d;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FETCH0, S_FETCH1, S_WAIT, S_ECHO, S_FIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_go_q, tx_go_d;
  logic              sw_rst_q, sw_rst_d;
  logic              sw_start_q, sw_start_d;
  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              done_q, done_d;
  logic              at_end_q, at_end_d;
  logic              last_q, last_d;
  logic              adv;

  logic start_hit, end_flag, key_match;
  assign start_hit = bus.rx_dv && (bus.rx_byte == START_CHAR);
  // A timer hit in this very cycle counts the same as one already latched.
  assign end_flag  = at_end_q || bus.timer_at_end;
  assign key_match = (bus.rx_byte == bus.rom_dout);

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_q <= '0;
      tx_byte_q  <= '0;
      tx_go_q    <= 1'b0;
      sw_rst_q   <= 1'b1;
      sw_start_q <= 1'b0;
      corr_q     <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
      at_end_q   <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_addr_q <= rom_addr_d;
      tx_byte_q  <= tx_byte_d;
      tx_go_q    <= tx_go_d;
      sw_rst_q   <= sw_rst_d;
      sw_start_q <= sw_start_d;
      corr_q     <= corr_d;
      err_q      <= err_d;
      done_q     <= done_d;
      at_end_q   <= at_end_d;
      last_q     <= last_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_ARM;
      S_ARM:    if (start_hit) state_d = S_FETCH0;
      S_FETCH0: state_d = S_FETCH1;
      S_FETCH1: state_d = (end_flag || bus.rom_dout == END_CHAR) ? S_FIN : S_WAIT;
      S_WAIT: begin
        if (end_flag)        state_d = S_FIN;
        else if (bus.rx_dv)  state_d = S_ECHO;
      end
      S_ECHO:   if (!bus.tx_busy) state_d = (last_q || end_flag) ? S_FIN : S_FETCH0;
      // The extra tx_go_q term keeps the CR strobe off the cycle right after an echo strobe.
      S_FIN:    if (!bus.tx_busy && !tx_go_q) state_d = S_DONE;
      S_DONE:   if (start_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values for the current state.
  always_comb begin
    rom_addr_d = rom_addr_q;
    tx_byte_d  = tx_byte_q;
    tx_go_d    = 1'b0;
    sw_rst_d   = sw_rst_q;
    sw_start_d = sw_start_q;
    corr_d     = corr_q;
    err_d      = err_q;
    at_end_d   = at_end_q;
    last_d     = last_q;
    adv        = 1'b0;
    done_d     = (state_d == S_DONE);

    if (bus.timer_at_end && state_q != S_IDLE && state_q != S_ARM) at_end_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        rom_addr_d = {bus.passage_sel, {OFF_W{1'b0}}};
        corr_d     = '0;
        err_d      = '0;
        at_end_d   = 1'b0;
        last_d     = 1'b0;
        sw_rst_d   = 1'b1;
        sw_start_d = 1'b0;
      end
      S_ARM: begin
        if (start_hit) begin
          sw_rst_d   = 1'b0;
          sw_start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!end_flag && bus.rx_dv) begin
          if (key_match) begin
            corr_d    = sat_inc(corr_q);
            tx_byte_d = bus.rom_dout;
            adv       = 1'b1;
          end else begin
            err_d     = sat_inc(err_q);
            tx_byte_d = bus.rx_byte;
            adv       = !STRICT;
          end
        end
      end
      S_ECHO: if (!bus.tx_busy) tx_go_d = 1'b1;
      S_FIN: begin
        sw_start_d = 1'b0;
        if (!bus.tx_busy && !tx_go_q) begin
          tx_byte_d = CR_CHAR;
          tx_go_d   = 1'b1;
        end
      end
      default: ;
    endcase

    // Advancing off the final byte of a region flags the end instead of
    // stepping into the next passage.
    if (adv) begin
      if (&rom_addr_q[OFF_W-1:0]) last_d = 1'b1;
      else                        rom_addr_d = rom_addr_q + ADDR_ONE;
    end
  end

  assign bus.rom_addr        = rom_addr_q;
  assign bus.tx_byte         = tx_byte_q;
  assign bus.tx_go           = tx_go_q;
  assign bus.stopwatch_rst   = sw_rst_q;
  assign bus.stopwatch_start = sw_start_q;
  assign bus.correct_cnt     = corr_q;
  assign bus.error_cnt       = err_q;
  assign bus.game_done       = done_q;
endmodule

// File: tb/tb_typing_session_core.sv
// Bench for typing_session_core: DUT A (11-bit ROM, STRICT=1) and DUT B
// (4-bit ROM with 4-byte regions, STRICT=0). Expected echo bytes are queued
// by the stimulus and consumed by per-DUT monitors on every tx_go.
module tb_typing_session_core;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typing_session_core_if #(.ADDR_W(11), .SEL_W(2), .CNT_W(12)) ifA();
  typing_session_core_if #(.ADDR_W(4),  .SEL_W(2), .CNT_W(12)) ifB();

  typing_session_core #(.ADDR_W(11), .SEL_W(2), .CNT_W(12), .STRICT(1'b1)) dutA (
    .clk(clk), .rst(rst), .bus(ifA));
  typing_session_core #(.ADDR_W(4), .SEL_W(2), .CNT_W(12), .STRICT(1'b0)) dutB (
    .clk(clk), .rst(rst), .bus(ifB));

  logic [7:0] memA [0:2047];
  logic [7:0] memB [0:15];
  always @(posedge clk) ifA.rom_dout <= memA[ifA.rom_addr];
  always @(posedge clk) ifB.rom_dout <= memB[ifB.rom_addr];

  logic [7:0] qA[$];
  logic [7:0] qB[$];
  int goCntA = 0, goCntB = 0, goCycA = 0;
  logic prevGoA = 1'b0, prevGoB = 1'b0;
  logic fullB = 1'b0, saw4B = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor A: every tx_go must match the oldest queued byte and never repeat back to back.
  always @(negedge clk) begin
    logic [7:0] e;
    if (ifA.tx_go === 1'b1) begin
      chk("txA_gap", 32'(prevGoA), 32'd0);
      if (qA.size() == 0) chk("txA_unexpected", 32'(ifA.tx_byte), 32'hffff_ffff);
      else begin
        e = qA.pop_front();
        chk("txA_byte", 32'(ifA.tx_byte), 32'(e));
      end
      goCntA++;
      goCycA = cyc;
    end
    prevGoA = ifA.tx_go;
  end

  // Monitor B.
  always @(negedge clk) begin
    logic [7:0] e;
    if (ifB.tx_go === 1'b1) begin
      chk("txB_gap", 32'(prevGoB), 32'd0);
      if (qB.size() == 0) chk("txB_unexpected", 32'(ifB.tx_byte), 32'hffff_ffff);
      else begin
        e = qB.pop_front();
        chk("txB_byte", 32'(ifB.tx_byte), 32'(e));
      end
      goCntB++;
    end
    prevGoB = ifB.tx_go;
    if (fullB && ifB.rom_addr == 4'd4) saw4B = 1'b1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic keyA(input logic [7:0] b);
    @(posedge clk); #1;
    ifA.rx_byte = b; ifA.rx_dv = 1'b1;
    @(posedge clk); #1;
    ifA.rx_dv = 1'b0;
  endtask

  task automatic keyB(input logic [7:0] b);
    @(posedge clk); #1;
    ifB.rx_byte = b; ifB.rx_dv = 1'b1;
    @(posedge clk); #1;
    ifB.rx_dv = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int goBefore, fallCyc;
    for (int i = 0; i < 2048; i++) memA[i] = 8'hff;
    for (int i = 0; i < 16; i++)   memB[i] = 8'hff;
    memA[11'h000] = "a"; memA[11'h001] = "b"; memA[11'h002] = 8'h00;
    memA[11'h200] = "a"; memA[11'h201] = "b"; memA[11'h202] = 8'h00;
    memA[11'h400] = "a"; memA[11'h401] = "b"; memA[11'h402] = "c"; memA[11'h403] = 8'h00;
    memA[11'h600] = "z"; memA[11'h601] = "y"; memA[11'h602] = 8'h00;
    memB[0] = "a"; memB[1] = "b"; memB[2] = "c"; memB[3] = "d";
    memB[4] = "a"; memB[5] = "b"; memB[6] = 8'h00;

    ifA.rx_byte = 8'h00; ifA.rx_dv = 1'b0; ifA.passage_sel = 2'd1;
    ifA.timer_at_end = 1'b0; ifA.tx_busy = 1'b0;
    ifB.rx_byte = 8'h00; ifB.rx_dv = 1'b0; ifB.passage_sel = 2'd1;
    ifB.timer_at_end = 1'b0; ifB.tx_busy = 1'b0;

    // Reset values.
    #2 rst = 1'b1;
    idle(2);
    chk("rst_addr",    32'(ifA.rom_addr), 32'h0);
    chk("rst_txbyte",  32'(ifA.tx_byte), 32'h0);
    chk("rst_txgo",    32'(ifA.tx_go), 32'h0);
    chk("rst_swrst",   32'(ifA.stopwatch_rst), 32'h1);
    chk("rst_swstart", 32'(ifA.stopwatch_start), 32'h0);
    chk("rst_corr",    32'(ifA.correct_cnt), 32'h0);
    chk("rst_err",     32'(ifA.error_cnt), 32'h0);
    chk("rst_done",    32'(ifA.game_done), 32'h0);
    rst = 1'b0;

    // Passage 1 "ab": two correct keys, CR at the end.
    idle(2);
    chk("s1_base",     32'(ifA.rom_addr), 32'h200);
    chk("s1_swrst",    32'(ifA.stopwatch_rst), 32'h1);
    keyA(8'h0d);
    chk("s1_swstart",  32'(ifA.stopwatch_start), 32'h1);
    chk("s1_swrst_lo", 32'(ifA.stopwatch_rst), 32'h0);
    ifA.passage_sel = 2'd3;
    idle(4);
    qA.push_back("a"); keyA("a"); idle(4);
    chk("s1_addr1", 32'(ifA.rom_addr), 32'h201);
    qA.push_back("b"); qA.push_back(8'h0d); keyA("b"); idle(8);
    chk("s1_addr2",    32'(ifA.rom_addr), 32'h202);
    chk("s1_corr",     32'(ifA.correct_cnt), 32'd2);
    chk("s1_err",      32'(ifA.error_cnt), 32'd0);
    chk("s1_done",     32'(ifA.game_done), 32'h1);
    chk("s1_swstop",   32'(ifA.stopwatch_start), 32'h0);
    chk("s1_qempty",   32'(qA.size()), 32'd0);

    // Restart from DONE on passage 0; STRICT mismatch holds the address.
    ifA.passage_sel = 2'd0;
    keyA(8'h0d); idle(2);
    chk("s2_clr_corr", 32'(ifA.correct_cnt), 32'd0);
    chk("s2_base",     32'(ifA.rom_addr), 32'h000);
    chk("s2_swrst",    32'(ifA.stopwatch_rst), 32'h1);
    chk("s2_notdone",  32'(ifA.game_done), 32'h0);
    keyA(8'h0d); idle(4);
    qA.push_back("x"); keyA("x"); idle(4);
    chk("s2_hold",     32'(ifA.rom_addr), 32'h000);
    chk("s2_err1",     32'(ifA.error_cnt), 32'd1);
    qA.push_back("a"); keyA("a"); idle(4);
    qA.push_back("b"); qA.push_back(8'h0d); keyA("b"); idle(8);
    chk("s2_corr",     32'(ifA.correct_cnt), 32'd2);
    chk("s2_err",      32'(ifA.error_cnt), 32'd1);
    chk("s2_done",     32'(ifA.game_done), 32'h1);
    chk("s2_qempty",   32'(qA.size()), 32'd0);

    // Passage 2: echo held off by tx_busy; a key during ECHO is dropped.
    ifA.passage_sel = 2'd2;
    keyA(8'h0d); idle(2); keyA(8'h0d); idle(4);
    goBefore = goCntA;
    qA.push_back("a");
    ifA.tx_busy = 1'b1;
    keyA("a");
    keyA("b");
    idle(8);
    ifA.tx_busy = 1'b0;
    fallCyc = cyc;
    idle(3);
    chk("s3_go_once",  32'(goCntA - goBefore), 32'd1);
    chk("s3_go_cyc",   32'(goCycA), 32'(fallCyc + 1));
    chk("s3_corr",     32'(ifA.correct_cnt), 32'd1);
    chk("s3_err",      32'(ifA.error_cnt), 32'd0);
    idle(2);

    // Timer hit together with a correct key: key ignored, CR sent.
    qA.push_back(8'h0d);
    @(posedge clk); #1;
    ifA.rx_byte = "b"; ifA.rx_dv = 1'b1; ifA.timer_at_end = 1'b1;
    @(posedge clk); #1;
    ifA.rx_dv = 1'b0; ifA.timer_at_end = 1'b0;
    idle(6);
    chk("s4_corr",     32'(ifA.correct_cnt), 32'd1);
    chk("s4_addr",     32'(ifA.rom_addr), 32'h401);
    chk("s4_done",     32'(ifA.game_done), 32'h1);
    chk("s4_swstop",   32'(ifA.stopwatch_start), 32'h0);
    chk("s4_qempty",   32'(qA.size()), 32'd0);

    // Timer hit during ECHO: echo still goes out, then FIN.
    keyA(8'h0d); idle(2); keyA(8'h0d); idle(4);
    qA.push_back("a"); qA.push_back(8'h0d);
    ifA.tx_busy = 1'b1;
    keyA("a");
    ifA.timer_at_end = 1'b1; idle(1); ifA.timer_at_end = 1'b0;
    idle(2);
    ifA.tx_busy = 1'b0;
    idle(8);
    chk("s5_corr",     32'(ifA.correct_cnt), 32'd1);
    chk("s5_addr",     32'(ifA.rom_addr), 32'h401);
    chk("s5_done",     32'(ifA.game_done), 32'h1);
    chk("s5_qempty",   32'(qA.size()), 32'd0);

    // Asynchronous reset in the middle of FETCH, right while an echo strobe is out.
    ifA.passage_sel = 2'd3;
    keyA(8'h0d); idle(2); keyA(8'h0d); idle(4);
    qA.push_back("z");
    keyA("z");
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("s6_addr",     32'(ifA.rom_addr), 32'h0);
    chk("s6_txbyte",   32'(ifA.tx_byte), 32'h0);
    chk("s6_txgo",     32'(ifA.tx_go), 32'h0);
    chk("s6_swrst",    32'(ifA.stopwatch_rst), 32'h1);
    chk("s6_swstart",  32'(ifA.stopwatch_start), 32'h0);
    chk("s6_corr",     32'(ifA.correct_cnt), 32'd0);
    goBefore = goCntA;
    idle(3);
    rst = 1'b0;
    idle(6);
    chk("s6_no_go",    32'(goCntA - goBefore), 32'd0);
    chk("s6_qempty",   32'(qA.size()), 32'd0);
    chk("s6_base",     32'(ifA.rom_addr), 32'h600);

    // DUT B, passage 1, STRICT=0: mismatches advance.
    chk("b_base",      32'(ifB.rom_addr), 32'h4);
    keyB(8'h0d); idle(4);
    qB.push_back("x"); keyB("x"); idle(4);
    chk("b_adv",       32'(ifB.rom_addr), 32'h5);
    chk("b_err1",      32'(ifB.error_cnt), 32'd1);
    qB.push_back("a"); qB.push_back(8'h0d); keyB("a"); idle(4);
    keyB("b"); idle(6);
    chk("b_err",       32'(ifB.error_cnt), 32'd2);
    chk("b_corr",      32'(ifB.correct_cnt), 32'd0);
    chk("b_addr",      32'(ifB.rom_addr), 32'h6);
    chk("b_done",      32'(ifB.game_done), 32'h1);

    // DUT B, region 0 full with no terminator: stop at offset 3.
    ifB.passage_sel = 2'd0;
    keyB(8'h0d); idle(2); keyB(8'h0d); idle(4);
    fullB = 1'b1;
    qB.push_back("a"); keyB("a"); idle(4);
    qB.push_back("b"); keyB("b"); idle(4);
    qB.push_back("c"); keyB("c"); idle(4);
    qB.push_back("d"); qB.push_back(8'h0d); keyB("d"); idle(8);
    chk("full_addr",   32'(ifB.rom_addr), 32'h3);
    chk("full_corr",   32'(ifB.correct_cnt), 32'd4);
    chk("full_done",   32'(ifB.game_done), 32'h1);
    chk("full_no4",    32'(saw4B), 32'h0);
    chk("full_qempty", 32'(qB.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/typing_session_core.md
# typing_session_core

Parametrised successor to the typing-test datapath. It folds the game sequencing into an internal FSM, so no external control strobes are needed. It supports multiple selectable passages held in one character ROM, counts correct and wrong keystrokes, and enforces a tx_busy handshake on the UART echo path. It sits between uart_rx/uart_tx, the passage ROM and the stopwatch.

## Interface
- ADDR_W, 11, ROM address width
- SEL_W, 2, passage-select width; passage region size is 2^(ADDR_W-SEL_W) bytes
- CNT_W, 12, width of correct/error counters
- STRICT, 1, 1 = a mismatch does not advance the address; 0 = a mismatch advances the address
- START_CHAR, 8'h0d, byte that starts a game, and restarts from DONE
- END_CHAR, 8'h00, end-of-text marker in ROM

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rx_byte  in  8  received byte
- rx_dv  in  1  1-cycle valid strobe for rx_byte
- passage_sel  in  SEL_W  passage select, latched in IDLE
- rom_dout  in  8  ROM data
- rom_addr  out  ADDR_W  ROM address, registered
- timer_at_end  in  1  stopwatch limit reached
- stopwatch_rst  out  1  stopwatch reset, registered
- stopwatch_start  out  1  stopwatch run, registered
- tx_busy  in  1  UART transmitter busy
- tx_byte  out  8  byte to transmit, registered
- tx_go  out  1  1-cycle transmit strobe
- correct_cnt  out  CNT_W  correct keystrokes
- error_cnt  out  CNT_W  wrong keystrokes
- game_done  out  1  high in DONE

## Operation
- ROM contract: rom_dout reflects the rom_addr sampled at the previous edge.
- FETCH therefore lasts exactly 2 cycles; rom_dout is used only on FETCH exit.
- Base address = passage_sel << (ADDR_W-SEL_W). Offset = low ADDR_W-SEL_W bits.
- at_end_seen: sticky flag, set whenever timer_at_end=1 outside IDLE/ARM; cleared in IDLE.

States:
- IDLE (1 cycle):
  - latch passage_sel and load rom_addr=base
  - clear both counters and at_end_seen
  - stopwatch_rst=1, stopwatch_start=0
  - → ARM
- ARM:
  - other rx bytes are ignored
  - on rx_dv && rx_byte==START_CHAR: stopwatch_rst=0, stopwatch_start=1 → FETCH
- FETCH (2 cycles), on exit:
  - at_end_seen or rom_dout==END_CHAR → FIN
  - otherwise → WAIT_KEY
- WAIT_KEY:
  - timer_at_end=1 → FIN; this wins over a same-cycle rx_dv, and that keystroke is not counted
  - rx_dv && rx_byte==rom_dout: correct_cnt++, tx_byte=rom_dout, advance → ECHO
  - rx_dv && mismatch: error_cnt++, tx_byte=rx_byte, advance only if STRICT=0 → ECHO
- Advance:
  - rom_addr++
  - if the offset was all-ones, set last_char and do not increment; never wrap into the next passage
- ECHO:
  - wait while tx_busy=1, then tx_go=1 for one cycle
  - then: last_char or at_end_seen → FIN; else → FETCH
- FIN:
  - stopwatch_start=0
  - once tx_busy=0: tx_byte=8'h0d, tx_go pulse → DONE
- DONE:
  - game_done=1; counters, address and stopwatch frozen
  - on rx_dv && rx_byte==START_CHAR → IDLE

Other rules:
- rx_dv outside ARM/WAIT_KEY/DONE is dropped, not queued.
- Counters saturate at all-ones; no wrap.

## Timing
- Reset (asynchronous): state=IDLE; rom_addr=0; tx_byte=0; tx_go=0; stopwatch_rst=1; stopwatch_start=0; both counters=0; game_done=0; at_end_seen=0; last_char=0.
- rst mid-game aborts immediately. No echo is sent and no tx_go fires after reset.
- All outputs are registered. tx_go is never high for 2 consecutive cycles.
- Keystroke to tx_go: 2 cycles minimum (rx_dv edge → ECHO → tx_go) when tx_busy=0. Otherwise tx_go fires the cycle after tx_busy falls.
- Keystroke to next WAIT_KEY: 4 cycles minimum (ECHO 1 + FETCH 2 + 1).
- START_CHAR in ARM → stopwatch_start=1 on the next edge; first compare is possible 3 cycles later.
- passage_sel changes outside IDLE have no effect.

## Test plan
- Passage 1 holds "ab\0". Send 0x0d, 'a', 'b' with tx_busy=0 → rom_addr goes 0x200→0x201→0x202; echoes 'a','b' then 0x0d; correct_cnt=2, error_cnt=0; game_done=1; stopwatch_start falls.
- STRICT=1, ROM "ab\0". Send 'x', 'a', 'b' → echoes 'x','a','b'; error_cnt=1, correct_cnt=2; rom_addr does not move on 'x'. Rerun with STRICT=0 → 'x' advances; 'a' vs 'b' mismatches; error_cnt=2, correct_cnt=0.
- Hold tx_busy=1 for 10 cycles after a correct key → tx_go fires exactly once, on the cycle after tx_busy falls; a rx_dv during ECHO is dropped (counters unchanged).
- Pulse timer_at_end in the same cycle as a correct rx_dv in WAIT_KEY → key not counted; FIN sends 0x0d; DONE reached. Separately, pulse timer_at_end during ECHO → echo completes, then FIN.
- Passage region full, with no END_CHAR in region 0 (ADDR_W=4, SEL_W=2 so regions are 4 bytes) → after the 4th correct key, rom_addr stays 0x3 and the block enters DONE without reading 0x4.
- Assert rst during FETCH → all outputs take reset values asynchronously. Then from DONE, send 0x0d → IDLE clears counters, loads the new passage_sel base, and asserts stopwatch_rst=1.
